pts_stream: RTL and testbench
=============================

Name: pts_stream

Overview:
- Parametrised parallel-to-serial converter for FFT result frames.
- Captures N_PTS samples of DATA_W bits in one cycle and streams them out one per accepted beat.
- Output uses a valid/ready handshake with backpressure and a last-beat marker.
- Supports back-to-back frames and reports dropped loads; sits between the FFT butterfly array and the serial output interface.

Parameters:
- DATA_W, 16: bits per sample.
- N_PTS, 32: samples per frame; power of two, 2..256.
- IDX_W, $clog2(N_PTS): index width (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- load_enable  in  1  request to capture par_in this cycle.
- par_in  in  N_PTS*DATA_W  frame; sample k at bits [k*DATA_W +: DATA_W].
- load_ready  out  1  combinational; a load is accepted this cycle when high.
- load_drop  out  1  registered one-cycle pulse: load_enable was high while load_ready was low.
- bitrev_sel  in  1  output-order select, sampled at load (see Optional Feature).
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  out_data holds a valid sample.
- out_data  out  DATA_W  current sample.
- out_last  out  1  high with the final sample of a frame.
- busy  out  1  a frame is being streamed (state SHIFT).

Behaviour:
- Reset is sampled on clk: when n_rst=0 at an edge, the following are cleared:
  - out_valid, out_last, busy, load_drop, out_data = 0
  - frame buffer = 0, index = 0, state = IDLE
- Reset mid-frame discards the frame; no partial output after reset.
- States:
  - IDLE: out_valid=0.
  - SHIFT: out_valid=1.
- Acceptance terms:
  - beat accepted = out_valid && out_ready.
  - load_ready = (state==IDLE) || (beat accepted && out_last).
- Load, when load_enable && load_ready at edge k:
  - buffer <= par_in; out_data <= sample order(0); index <= 1.
  - out_valid <= 1; out_last <= (N_PTS==1 ? 1 : 0), though N_PTS>=2 in practice.
  - state <= SHIFT; busy <= 1.
  - First sample is visible in cycle k+1, so latency is 1 cycle.
- Beat accepted, not last: out_data <= buffer[order(index)]; index <= index+1; out_last <= (index==N_PTS-1).
- Beat accepted with out_last and no simultaneous load: out_valid <= 0, out_last <= 0, busy <= 0, state <= IDLE. out_data holds its last value.
- Beat accepted with out_last and load_enable in the same cycle: the new frame loads with no bubble, and out_valid stays 1.
- Backpressure: while out_valid && !out_ready, out_data, out_last and index hold stable.
- Dropped load: load_enable && !load_ready → the buffer is unchanged and load_drop=1 in the next cycle only.
- Loads always take priority over shifting within the load_ready window. There is no other path for a load.
- Exactly N_PTS beats per frame with out_last on beat N_PTS-1.
- Index wraps only via reload or IDLE.
- order(i) = i by default.

Optional Feature:
- Macro: PTS_BITREV_EN.
- Defined:
  - bitrev_sel is registered at each accepted load.
  - When it is 1, order(i) = bit-reverse of i over IDX_W bits, which converts FFT bit-reversed output to natural order.
  - When it is 0, order(i) = i.
- Undefined:
  - The bitrev_sel port remains, is ignored and is documented as tie-0.
  - order(i) = i and no reversal logic is synthesised.

Decomposition:
- Package pts_pkg holds:
  - typedef enum logic {IDLE, SHIFT} pts_state_t
  - function bitrev(idx, width)
  - localparam default DATA_W / N_PTS constants shared with the FFT top.
- One sub-module, pts_idx_gen:
  - index counter with clear/increment/hold, last detect, and optional bit-reverse mapping.
  - Ports: clk, n_rst, clr, inc, rev, idx_out, last.
- Buffer, handshake and FSM stay in pts_stream.

Test Plan:
- Reset then single frame:
  - Stimulus: N_PTS=32, par_in sample k = 16'h0100+k, load in cycle 0, out_ready=1.
  - Response: out_data 16'h0100..16'h011F in cycles 1..32; out_last only in cycle 32; out_valid=0 in cycle 33.
- Backpressure:
  - Stimulus: out_ready low in cycles 3-6 of a frame.
  - Response: out_data stays at sample 2 across those cycles; no skipped or repeated samples; total 32 accepted beats.
- Back-to-back frames:
  - Stimulus: second frame (samples 16'h0200+k) loads on the cycle the last beat of frame 1 is accepted.
  - Response: 16'h011F is followed immediately by 16'h0200 with no out_valid gap.
- Dropped load:
  - Stimulus: load_enable at beat 10 of a frame.
  - Response: load_drop=1 for exactly one cycle; the stream continues with the original sample 10 onward.
- Reset mid-frame:
  - Stimulus: n_rst=0 for one edge at beat 15.
  - Response: all outputs 0 on the next cycle; a subsequent load restarts from sample 0.
- PTS_BITREV_EN with bitrev_sel=1, N_PTS=8, sample k = k:
  - Response: output order 0, 4, 2, 6, 1, 5, 3, 7.
  - Same stimulus with the macro undefined: output order 0..7.

Source files
------------

// File: rtl/pts_pkg.sv
// rtl/pts_pkg.sv - shared types, defaults and bit-reverse helper for pts_stream
package pts_pkg;

   localparam int PTS_DATA_W = 16;
   localparam int PTS_N_PTS  = 32;

   typedef enum logic {IDLE, SHIFT} pts_state_t;

   // Reverses the low 'width' bits of idx; width is at most 8 (N_PTS <= 256).
   function automatic logic [7:0] bitrev(input logic [7:0] idx, input int width);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < width) r[i] = idx[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/pts_idx_gen.sv
// rtl/pts_idx_gen.sv - sample index counter with last detect and optional bit-reverse mapping
// Reverse mapping is built only when PTS_BITREV_EN is defined; otherwise rev is ignored.
module pts_idx_gen
   import pts_pkg::*;
#(
   parameter int N_PTS = 32,
   parameter int IDX_W = $clog2(N_PTS)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             rev,
   output logic [IDX_W-1:0] idx_out,
   output logic             last
);

   logic [IDX_W-1:0] idx_q;

   // Sample 0 leaves with the load itself, so a cleared counter restarts at 1.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         idx_q <= '0;
      end else if (clr) begin
         idx_q <= IDX_W'(1);
      end else if (inc) begin
         idx_q <= idx_q + IDX_W'(1);
      end
   end

   assign last = (idx_q == IDX_W'(N_PTS - 1));

`ifdef PTS_BITREV_EN
   logic rev_q;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rev_q <= 1'b0;
      end else if (clr) begin
         rev_q <= rev;
      end
   end

   assign idx_out = rev_q ? IDX_W'(bitrev(8'(idx_q), IDX_W)) : idx_q;
`else
   logic unused_rev;

   assign unused_rev = rev;
   assign idx_out    = idx_q;
`endif

endmodule

// File: rtl/pts_stream.sv
// rtl/pts_stream.sv - parallel-to-serial FFT frame streamer with valid/ready output
// Optional bit-reversed read order enabled by PTS_BITREV_EN (bitrev_sel is tie-0 otherwise).
module pts_stream
   import pts_pkg::*;
#(
   parameter int DATA_W = PTS_DATA_W,
   parameter int N_PTS  = PTS_N_PTS
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    load_enable,
   input  logic [N_PTS*DATA_W-1:0] par_in,
   output logic                    load_ready,
   output logic                    load_drop,
   input  logic                    bitrev_sel,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int IDX_W = $clog2(N_PTS);

   pts_state_t              state;
   pts_state_t              state_d;
   logic [N_PTS*DATA_W-1:0] frame_q;
   logic [IDX_W-1:0]        idx_out;
   logic                    idx_last;
   logic                    beat;
   logic                    load_fire;

   assign out_valid  = (state == SHIFT);
   assign busy       = (state == SHIFT);
   assign beat       = out_valid && out_ready;
   assign load_ready = (state == IDLE) || (beat && out_last);
   assign load_fire  = load_enable && load_ready;

   pts_idx_gen #(
      .N_PTS (N_PTS),
      .IDX_W (IDX_W)
   ) u_idx_gen (
      .clk     (clk),
      .n_rst   (n_rst),
      .clr     (load_fire),
      .inc     (beat && !out_last),
      .rev     (bitrev_sel),
      .idx_out (idx_out),
      .last    (idx_last)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // A load in the last-beat cycle wins, giving back-to-back frames without a bubble.
   always_comb begin
      state_d = state;
      if (load_fire) begin
         state_d = SHIFT;
      end else if (beat && out_last) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         frame_q   <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         load_drop <= 1'b0;
      end else begin
         load_drop <= load_enable && !load_ready;
         if (load_fire) begin
            frame_q  <= par_in;
            out_data <= par_in[DATA_W-1:0];
            out_last <= (N_PTS == 1);
         end else if (beat) begin
            if (out_last) begin
               out_last <= 1'b0;
            end else begin
               out_data <= frame_q[int'(idx_out)*DATA_W +: DATA_W];
               out_last <= idx_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_pts_stream.sv
// tb/tb_pts_stream.sv - scoreboard bench for pts_stream (N_PTS=32 and N_PTS=8 instances)
module tb_pts_stream;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;

   logic          load_enable_a = 1'b0;
   logic [511:0]  par_in_a = '0;
   logic          bitrev_sel_a = 1'b0;
   logic          out_ready_a = 1'b1;
   logic          load_ready_a, load_drop_a, out_valid_a, out_last_a, busy_a;
   logic [15:0]   out_data_a;

   logic          load_enable_b = 1'b0;
   logic [127:0]  par_in_b = '0;
   logic          bitrev_sel_b = 1'b0;
   logic          out_ready_b = 1'b1;
   logic          load_ready_b, load_drop_b, out_valid_b, out_last_b, busy_b;
   logic [15:0]   out_data_b;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   pops_a = 0;
   int   pops_b = 0;

   always #5 clk = ~clk;

   pts_stream #(.DATA_W(16), .N_PTS(32)) dut_a (
      .clk(clk), .n_rst(n_rst), .load_enable(load_enable_a), .par_in(par_in_a),
      .load_ready(load_ready_a), .load_drop(load_drop_a), .bitrev_sel(bitrev_sel_a),
      .out_ready(out_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
      .out_last(out_last_a), .busy(busy_a)
   );

   pts_stream #(.DATA_W(16), .N_PTS(8)) dut_b (
      .clk(clk), .n_rst(n_rst), .load_enable(load_enable_b), .par_in(par_in_b),
      .load_ready(load_ready_b), .load_drop(load_drop_b), .bitrev_sel(bitrev_sel_b),
      .out_ready(out_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
      .out_last(out_last_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mk_frame(input logic [15:0] base);
      logic [511:0] f;
      for (int k = 0; k < 32; k++) f[k*16 +: 16] = base + 16'(k);
      return f;
   endfunction

   task automatic load_a(input logic [15:0] base);
      exp_t e;
      par_in_a = mk_frame(base);
      load_enable_a = 1'b1;
      for (int k = 0; k < 32; k++) begin
         e.data = base + 16'(k);
         e.last = (k == 31);
         exp_a.push_back(e);
      end
      step();
      load_enable_a = 1'b0;
   endtask

   task automatic drain_a(input string name);
      int n = 0;
      while (out_valid_a && n < 80) begin
         step();
         n++;
      end
      chk(name, {31'd0, out_valid_a}, 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (n_rst && out_valid_a && out_ready_a) begin
         if (exp_a.size() == 0) begin
            chk("a_unexpected_beat", {16'd0, out_data_a}, 32'hFFFF_FFFF);
         end else begin
            e = exp_a.pop_front();
            chk("a_data", {16'd0, out_data_a}, {16'd0, e.data});
            chk("a_last", {31'd0, out_last_a}, {31'd0, e.last});
         end
         pops_a++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (n_rst && out_valid_b && out_ready_b) begin
         if (exp_b.size() == 0) begin
            chk("b_unexpected_beat", {16'd0, out_data_b}, 32'hFFFF_FFFF);
         end else begin
            e = exp_b.pop_front();
            chk("b_data", {16'd0, out_data_b}, {16'd0, e.data});
            chk("b_last", {31'd0, out_last_b}, {31'd0, e.last});
         end
         pops_b++;
      end
   end

   initial begin
      int start;
      int order[8];
      exp_t e;

      // Reset state
      step();
      step();
      chk("rst_valid", {31'd0, out_valid_a}, 0);
      chk("rst_last", {31'd0, out_last_a}, 0);
      chk("rst_busy", {31'd0, busy_a}, 0);
      chk("rst_drop", {31'd0, load_drop_a}, 0);
      chk("rst_data", {16'd0, out_data_a}, 0);
      chk("rst_load_ready", {31'd0, load_ready_a}, 1);
      n_rst = 1'b1;
      step();

      // Single frame, full throughput
      start = pops_a;
      load_a(16'h0100);
      chk("single_busy", {31'd0, busy_a}, 1);
      repeat (32) step();
      chk("single_idle_valid", {31'd0, out_valid_a}, 0);
      chk("single_idle_busy", {31'd0, busy_a}, 0);
      chk("single_beats", 32'(pops_a - start), 32);

      // Backpressure in cycles 3..6 holds sample 2
      start = pops_a;
      load_a(16'h0100);
      for (int cyc = 1; cyc <= 6; cyc++) begin
         out_ready_a = !(cyc >= 3 && cyc <= 6);
         @(negedge clk);
         if (!out_ready_a) begin
            chk("bp_hold_data", {16'd0, out_data_a}, 32'h0102);
            chk("bp_hold_valid", {31'd0, out_valid_a}, 1);
         end
         step();
      end
      out_ready_a = 1'b1;
      drain_a("bp_drain");
      chk("bp_beats", 32'(pops_a - start), 32);

      // Back-to-back frames with load on the final accepted beat
      load_a(16'h0100);
      repeat (31) step();
      chk("b2b_last_seen", {31'd0, out_last_a}, 1);
      par_in_a = mk_frame(16'h0200);
      load_enable_a = 1'b1;
      for (int k = 0; k < 32; k++) begin
         e.data = 16'h0200 + 16'(k);
         e.last = (k == 31);
         exp_a.push_back(e);
      end
      @(negedge clk);
      chk("b2b_load_ready", {31'd0, load_ready_a}, 1);
      step();
      load_enable_a = 1'b0;
      chk("b2b_no_gap", {31'd0, out_valid_a}, 1);
      chk("b2b_first", {16'd0, out_data_a}, 32'h0200);
      drain_a("b2b_drain");

      // Dropped load at beat 10
      load_a(16'h0300);
      repeat (10) step();
      par_in_a = mk_frame(16'h0400);
      load_enable_a = 1'b1;
      @(negedge clk);
      chk("drop_load_ready", {31'd0, load_ready_a}, 0);
      step();
      load_enable_a = 1'b0;
      chk("drop_pulse", {31'd0, load_drop_a}, 1);
      chk("drop_continue", {16'd0, out_data_a}, 32'h030B);
      step();
      chk("drop_pulse_end", {31'd0, load_drop_a}, 0);
      drain_a("drop_drain");

      // Reset mid-frame at beat 15
      load_a(16'h0500);
      repeat (15) step();
      chk("mid_before", {16'd0, out_data_a}, 32'h050F);
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      exp_a.delete();
      chk("mid_rst_valid", {31'd0, out_valid_a}, 0);
      chk("mid_rst_last", {31'd0, out_last_a}, 0);
      chk("mid_rst_busy", {31'd0, busy_a}, 0);
      chk("mid_rst_data", {16'd0, out_data_a}, 0);
      chk("mid_rst_drop", {31'd0, load_drop_a}, 0);
      step();
      start = pops_a;
      load_a(16'h0600);
      chk("mid_restart", {16'd0, out_data_a}, 32'h0600);
      drain_a("mid_drain");
      chk("mid_beats", 32'(pops_a - start), 32);

      // N_PTS=8, bitrev_sel=1, sample k = k
`ifdef PTS_BITREV_EN
      order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
      order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
      for (int k = 0; k < 8; k++) par_in_b[k*16 +: 16] = 16'(k);
      for (int k = 0; k < 8; k++) begin
         e.data = 16'(order[k]);
         e.last = (k == 7);
         exp_b.push_back(e);
      end
      start = pops_b;
      bitrev_sel_b = 1'b1;
      load_enable_b = 1'b1;
      step();
      load_enable_b = 1'b0;
      bitrev_sel_b = 1'b0;
      chk("b_busy", {31'd0, busy_b}, 1);
      for (int n = 0; n < 40 && out_valid_b; n++) step();
      chk("b_idle", {31'd0, out_valid_b}, 0);
      chk("b_beats", 32'(pops_b - start), 8);

      chk("a_queue_empty", 32'(exp_a.size()), 0);
      chk("b_queue_empty", 32'(exp_b.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
